muldiv_sequencer: RTL

- Controller between the CPU control unit and the multi-cycle multiply and divide datapaths.
- Accepts one HI/LO operation at a time (MULT, DIV, MTHI, MTLO) and launches the correct unit with a one-cycle start pulse.
- Waits for that unit's done, commits the result to the architectural HI/LO registers, and stalls MFHI/MFLO reads while an operation is in flight.
- Detects divide-by-zero and unit timeouts.

---
 rtl/muldiv_sequencer_if.sv | 61 ++++++
 rtl/muldiv_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the HI/LO sequencer and its environment: the control-unit request and
// read ports, the multiply/divide unit handshakes and the architectural status outputs.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_ready;

    logic             mul_start;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_done;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    logic             div_start;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_done;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    logic             rd_req;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             stall;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             dbz;
    logic             timeout_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  mul_done, mul_hi, mul_lo,
        input  div_done, div_hi, div_lo,
        input  rd_req, rd_sel,
        output req_ready,
        output mul_start, mul_a, mul_b,
        output div_start, div_a, div_b,
        output rd_data, stall,
        output hi, lo, busy, done, dbz, timeout_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output mul_done, mul_hi, mul_lo,
        output div_done, div_hi, div_lo,
        output rd_req, rd_sel,
        input  req_ready,
        input  mul_start, mul_a, mul_b,
        input  div_start, div_a, div_b,
        input  rd_data, stall,
        input  hi, lo, busy, done, dbz, timeout_err
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one HI/LO operation at a time onto the multi-cycle multiply/divide units,
// commits results to HI/LO, stalls MFHI/MFLO while busy, flags divide-by-zero and timeouts.
module muldiv_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 48,
    parameter int CNT_W   = 6
) (
    input logic               clock,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic             sel_div;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] mul_a_q;
    logic [WIDTH-1:0] mul_b_q;
    logic [WIDTH-1:0] div_a_q;
    logic [WIDTH-1:0] div_b_q;
    logic             done_q;
    logic             dbz_q;
    logic             timeout_q;

    op_t              op;
    logic             accept;
    logic             b_zero;
    logic             launch_req;
    logic             unit_done;
    logic [WIDTH-1:0] unit_hi;
    logic [WIDTH-1:0] unit_lo;

    assign op         = op_t'(bus.req_op);
    assign accept     = bus.req_valid && (state == IDLE);
    assign b_zero     = (bus.req_b == '0);
    assign launch_req = (op == OP_MULT) || ((op == OP_DIV) && !b_zero);

    // Only the selected unit is listened to; the other unit's done is ignored.
    assign unit_done = sel_div ? bus.div_done : bus.mul_done;
    assign unit_hi   = sel_div ? bus.div_hi   : bus.mul_hi;
    assign unit_lo   = sel_div ? bus.div_lo   : bus.mul_lo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && launch_req) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (unit_done || (cnt == CNT_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_div   <= 1'b0;
            cnt       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            div_a_q   <= '0;
            div_b_q   <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT: begin
                                mul_a_q <= bus.req_a;
                                mul_b_q <= bus.req_b;
                                sel_div <= 1'b0;
                            end
                            OP_DIV: begin
                                if (b_zero) begin
                                    dbz_q <= 1'b1;
                                end else begin
                                    div_a_q <= bus.req_a;
                                    div_b_q <= bus.req_b;
                                    sel_div <= 1'b1;
                                end
                            end
                            OP_MTHI: hi_q <= bus.req_a;
                            OP_MTLO: lo_q <= bus.req_a;
                            default: ;
                        endcase
                    end
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    // A done arriving on the final counted cycle still commits.
                    if (unit_done) begin
                        hi_q   <= unit_hi;
                        lo_q   <= unit_lo;
                        done_q <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Start pulses decode straight from state so an async reset drops them at once.
    assign bus.mul_start   = (state == LAUNCH) && !sel_div;
    assign bus.div_start   = (state == LAUNCH) &&  sel_div;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.div_a       = div_a_q;
    assign bus.div_b       = div_b_q;

    assign bus.req_ready   = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.stall       = bus.rd_req && (state != IDLE);
    assign bus.rd_data     = bus.rd_sel ? hi_q : lo_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.done        = done_q;
    assign bus.dbz         = dbz_q;
    assign bus.timeout_err = timeout_q;
endmodule
